ysyx_22050133_axi_sram: RTL and testbench

//  AXI slave memory that terminates the master port of the AXI arbiter (IFU/LSU mux) in the NPC.

---
 rtl/ysyx_22050133_axi_sram_if.sv | 38 +++
 rtl/ysyx_22050133_axi_sram.sv | 161 ++++++++++++++++
 tb/tb_ysyx_22050133_axi_sram.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050133_axi_sram_if.sv
// AXI channel bundle between the arbiter master port and the SRAM slave.
// The master drives address/data/ready-for-response; the slave drives readies, valids and responses.
interface ysyx_22050133_axi_sram_if #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic                          aw_ready;
    logic                          aw_valid;
    logic [AXI_ADDR_WIDTH-1:0]     aw_addr;
    logic                          aw_len;
    logic                          w_ready;
    logic                          w_valid;
    logic [AXI_DATA_WIDTH-1:0]     w_data;
    logic [AXI_DATA_WIDTH/8-1:0]   w_strb;
    logic                          b_valid;
    logic                          b_ready;
    logic [1:0]                    b_resp;
    logic                          ar_ready;
    logic                          ar_valid;
    logic [AXI_ADDR_WIDTH-1:0]     ar_addr;
    logic                          ar_len;
    logic                          r_valid;
    logic                          r_ready;
    logic [1:0]                    r_resp;
    logic [AXI_DATA_WIDTH-1:0]     r_data;

    modport master (
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_resp, r_data,
        output aw_valid, aw_addr, aw_len, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, ar_len, r_ready
    );

    modport slave (
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_resp, r_data,
        input  aw_valid, aw_addr, aw_len, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, ar_len, r_ready
    );
endinterface

// File: rtl/ysyx_22050133_axi_sram.sv
// AXI slave SRAM with independent read/write FSMs, 1-2 beat bursts and byte strobes.
// Define AXI_SRAM_DELAY_EN to insert LAT idle cycles before each read beat and write response.
module ysyx_22050133_axi_sram #(
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        DEPTH          = 4096,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = AXI_ADDR_WIDTH'(32'h80000000),
    parameter int                        LAT            = 2
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_22050133_axi_sram_if.slave axi
);
    localparam int                        IDX_W  = $clog2(DEPTH);
    localparam int                        STRB_W = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH-1:0] SPAN   = AXI_ADDR_WIDTH'(DEPTH * 8);

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    // Below-base addresses wrap to huge offsets, so one unsigned compare covers both bounds.
    logic [AXI_ADDR_WIDTH-1:0] ar_off, aw_off;
    logic                      ar_err, aw_err;
    logic [IDX_W-1:0]          ar_idx, aw_idx;
    logic                      unused_lsb;

    assign ar_off     = axi.ar_addr - BASE_ADDR;
    assign aw_off     = axi.aw_addr - BASE_ADDR;
    assign ar_err     = (ar_off >= SPAN);
    assign aw_err     = (aw_off >= SPAN);
    assign ar_idx     = ar_off[IDX_W+2:3];
    assign aw_idx     = aw_off[IDX_W+2:3];
    assign unused_lsb = ^{ar_off[2:0], aw_off[2:0]};

    logic [0:0]                r_state;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_len, r_cnt, r_err;
    logic [AXI_DATA_WIDTH-1:0] r_data_q;
    logic [1:0]                w_state;
    logic [IDX_W-1:0]          w_idx;
    logic                      w_len, w_cnt, w_err;
    logic                      r_go, b_go;
    logic                      r_valid, b_valid;
    logic                      ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic                      r_last, w_last;

    assign axi.ar_ready = ~rst & (r_state == R_IDLE);
    assign axi.aw_ready = ~rst & (w_state == W_IDLE);
    assign axi.w_ready  = ~rst & (w_state == W_DATA);
    assign r_valid      = (r_state == R_DATA) & r_go;
    assign b_valid      = (w_state == W_RESP) & b_go;
    assign axi.r_valid  = r_valid;
    assign axi.b_valid  = b_valid;
    assign axi.r_resp   = (r_valid & r_err) ? 2'b10 : 2'b00;
    assign axi.b_resp   = (b_valid & w_err) ? 2'b10 : 2'b00;
    assign axi.r_data   = r_data_q;

    assign ar_hs  = axi.ar_valid & axi.ar_ready;
    assign r_hs   = r_valid & axi.r_ready;
    assign aw_hs  = axi.aw_valid & axi.aw_ready;
    assign w_hs   = axi.w_valid & axi.w_ready;
    assign b_hs   = b_valid & axi.b_ready;
    assign r_last = (r_cnt == r_len);
    assign w_last = (w_cnt == w_len);

`ifdef AXI_SRAM_DELAY_EN
    logic [7:0] r_wait, b_wait;

    assign r_go = (r_wait == 8'd0);
    assign b_go = (b_wait == 8'd0);

    // Every read beat and every write response is preceded by LAT silent cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= 8'd0;
            b_wait <= 8'd0;
        end else begin
            if (ar_hs || (r_hs && !r_last)) r_wait <= 8'(LAT);
            else if (r_wait != 8'd0)        r_wait <= r_wait - 8'd1;
            if (w_hs && w_last)             b_wait <= 8'(LAT);
            else if (b_wait != 8'd0)        b_wait <= b_wait - 8'd1;
        end
    end
`else
    localparam int LAT_UNUSED = LAT;

    assign r_go = 1'b1;
    assign b_go = 1'b1;
`endif

    // Read data is sampled from the array on the same edge a write lands, so it sees the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= R_IDLE;
            r_idx    <= '0;
            r_len    <= 1'b0;
            r_cnt    <= 1'b0;
            r_err    <= 1'b0;
            r_data_q <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    r_idx    <= ar_idx;
                    r_len    <= axi.ar_len;
                    r_err    <= ar_err;
                    r_cnt    <= 1'b0;
                    r_data_q <= ar_err ? '0 : mem[ar_idx];
                    r_state  <= R_DATA;
                end
                R_DATA: if (r_hs) begin
                    if (r_last) begin
                        r_state <= R_IDLE;
                    end else begin
                        r_cnt    <= 1'b1;
                        r_data_q <= r_err ? '0 : mem[r_idx + IDX_W'(1)];
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_idx   <= '0;
            w_len   <= 1'b0;
            w_cnt   <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (aw_hs) begin
                    w_idx   <= aw_idx;
                    w_len   <= axi.aw_len;
                    w_err   <= aw_err;
                    w_cnt   <= 1'b0;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    if (w_last) w_state <= W_RESP;
                    else        w_cnt   <= 1'b1;
                end
                W_RESP: if (b_hs) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs && !w_err) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (axi.w_strb[i]) mem[w_idx + IDX_W'(w_cnt)][i*8 +: 8] <= axi.w_data[i*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ysyx_22050133_axi_sram.sv
// Randomized self-checking bench for ysyx_22050133_axi_sram against a word-array reference model.
module tb_ysyx_22050133_axi_sram;
    localparam int          DW    = 64;
    localparam int          AW    = 32;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 2;
    localparam logic [31:0] BASE  = 32'h80000000;
`ifdef AXI_SRAM_DELAY_EN
    localparam int RLAT = 1 + LAT;
`else
    localparam int RLAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [63:0] model_mem [DEPTH];

    ysyx_22050133_axi_sram_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) bus ();

    ysyx_22050133_axi_sram #(
        .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LAT(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .axi(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit model_ok(input logic [31:0] addr);
        longint unsigned a, lo, hi;
        a  = longint'(addr);
        lo = longint'(BASE);
        hi = lo + longint'(DEPTH) * 8;
        return (a >= lo) && (a < hi);
    endfunction

    function automatic int model_idx(input logic [31:0] addr, input int beat);
        longint unsigned a;
        a = longint'(addr) - longint'(BASE);
        return int'((a / 8 + longint'(beat)) % longint'(DEPTH));
    endfunction

    function automatic logic [63:0] model_read(input logic [31:0] addr, input int beat);
        if (!model_ok(addr)) return 64'd0;
        return model_mem[model_idx(addr, beat)];
    endfunction

    function automatic void model_write(input logic [31:0] addr, input int beat,
                                        input logic [63:0] d, input logic [7:0] s);
        int k;
        if (!model_ok(addr)) return;
        k = model_idx(addr, beat);
        for (int i = 0; i < 8; i++) if (s[i]) model_mem[k][i*8 +: 8] = d[i*8 +: 8];
    endfunction

    task automatic bus_idle();
        bus.aw_valid = 0; bus.aw_addr = '0; bus.aw_len = 0;
        bus.w_valid  = 0; bus.w_data  = '0; bus.w_strb = '0;
        bus.b_ready  = 0;
        bus.ar_valid = 0; bus.ar_addr = '0; bus.ar_len = 0;
        bus.r_ready  = 0;
    endtask

    // Drivers start at a falling edge and return at a falling edge.
    task automatic do_write(input logic [31:0] addr, input logic len, input logic [63:0] d0, d1,
                            input logic [7:0] s0, s1, output logic [1:0] resp, output bit to);
        int n;
        to = 0; resp = 2'b11;
        bus.aw_addr = addr; bus.aw_len = len; bus.aw_valid = 1;
        n = 0;
        while (bus.aw_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) to = 1;
        @(negedge clk); bus.aw_valid = 0;
        for (int b = 0; b <= int'(len); b++) begin
            bus.w_data = (b == 0) ? d0 : d1;
            bus.w_strb = (b == 0) ? s0 : s1;
            bus.w_valid = 1;
            n = 0;
            while (bus.w_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            if (n >= 20) to = 1;
            @(negedge clk); bus.w_valid = 0;
        end
        bus.b_ready = 1;
        n = 0;
        while (bus.b_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) to = 1;
        resp = bus.b_resp;
        @(negedge clk); bus.b_ready = 0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic len, input int stall,
                           output logic [63:0] d0, d1, output logic [1:0] r0, r1,
                           output int lat, output bit stable, output logic arr, output bit to);
        int n, hs;
        logic [63:0] hold;
        logic [1:0]  hresp;
        to = 0; stable = 1; lat = -1; d0 = '0; d1 = '0; r0 = 2'b11; r1 = 2'b11;
        bus.ar_addr = addr; bus.ar_len = len; bus.ar_valid = 1;
        n = 0;
        while (bus.ar_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) to = 1;
        hs = cyc;
        @(negedge clk); bus.ar_valid = 0;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (bus.r_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            if (n >= 20) to = 1;
            if (b == 0) lat = cyc - hs;
            hold = bus.r_data; hresp = bus.r_resp;
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    @(negedge clk);
                    if (bus.r_valid !== 1'b1 || bus.r_data !== hold || bus.r_resp !== hresp) stable = 0;
                end
            end
            if (b == 0) begin d0 = bus.r_data; r0 = bus.r_resp; end
            else        begin d1 = bus.r_data; r1 = bus.r_resp; end
            bus.r_ready = 1;
            @(negedge clk); bus.r_ready = 0;
        end
        arr = bus.ar_ready;
    endtask

    task automatic test_reset();
        int n;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.aw_ready, bus.w_ready, bus.b_valid, bus.b_resp, bus.ar_ready, bus.r_valid,
             bus.r_resp, bus.r_data} !== '0) begin
            errors++; $display("FAIL reset_outputs got nonzero outputs while rst=1");
        end
        rst = 0;
        #1;
        checks++;
        if (bus.ar_ready !== 1'b1 || bus.aw_ready !== 1'b1 || bus.w_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release ar_ready=%b aw_ready=%b w_ready=%b required 1 1 0",
                     bus.ar_ready, bus.aw_ready, bus.w_ready);
        end
        @(negedge clk);
        bus.ar_addr = BASE + 32'h40; bus.ar_len = 1; bus.ar_valid = 1;
        @(negedge clk); bus.ar_valid = 0;
        n = 0;
        while (bus.r_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL reset_burst_start r_valid never rose"); end
        #2 rst = 1;
        #1;
        checks++;
        if ({bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid, bus.r_resp,
             bus.r_data} !== '0) begin
            errors++;
            $display("FAIL reset_midburst r_valid=%b r_data=%h ar_ready=%b required all 0",
                     bus.r_valid, bus.r_data, bus.ar_ready);
        end
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (bus.ar_ready !== 1'b1 || bus.aw_ready !== 1'b1 || bus.r_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort ar_ready=%b aw_ready=%b r_valid=%b required 1 1 0",
                     bus.ar_ready, bus.aw_ready, bus.r_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [63:0] d0, d1; logic [1:0] resp, r0, r1; int lat; bit st, to, to2; logic arr;
        do_write(32'h80000010, 0, 64'h1122334455667788, 64'd0, 8'hFF, 8'h00, resp, to);
        model_write(32'h80000010, 0, 64'h1122334455667788, 8'hFF);
        do_read(32'h80000010, 0, 0, d0, d1, r0, r1, lat, st, arr, to2);
        checks++;
        if (to || to2) begin errors++; $display("FAIL basic_timeout handshake bound expired"); end
        checks++;
        if (resp !== 2'b00) begin errors++; $display("FAIL basic_bresp got %b required 00", resp); end
        checks++;
        if (d0 !== model_read(32'h80000010, 0) || r0 !== 2'b00) begin
            errors++;
            $display("FAIL basic_rdata got %h/%b required %h/00", d0, r0, model_read(32'h80000010, 0));
        end
        checks++;
        if (lat !== RLAT) begin errors++; $display("FAIL basic_latency got %0d required %0d", lat, RLAT); end
    endtask

    task automatic test_strobe();
        logic [63:0] d0, d1; logic [1:0] resp, r0, r1; int lat; bit st, to, to2; logic arr;
        do_write(32'h80000010, 0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 8'h0F, 8'h00, resp, to);
        model_write(32'h80000010, 0, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        do_read(32'h80000017, 0, 0, d0, d1, r0, r1, lat, st, arr, to2);
        checks++;
        if (to || to2 || d0 !== 64'h11223344FFFFFFFF || d0 !== model_read(32'h80000010, 0)) begin
            errors++; $display("FAIL strobe_merge got %h required %h", d0, 64'h11223344FFFFFFFF);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] d0, d1, a, b; logic [1:0] resp, r0, r1; int lat; bit st, to, to2; logic arr;
        logic [31:0] top;
        top = BASE + 32'((DEPTH - 1) * 8);
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        do_write(top, 1, a, b, 8'hFF, 8'hFF, resp, to);
        model_write(top, 0, a, 8'hFF); model_write(top, 1, b, 8'hFF);
        do_read(top, 1, 3, d0, d1, r0, r1, lat, st, arr, to2);
        checks++;
        if (to || to2) begin errors++; $display("FAIL wrap_timeout handshake bound expired"); end
        checks++;
        if (!st) begin errors++; $display("FAIL wrap_stall beat 1 changed while r_ready low"); end
        checks++;
        if (d0 !== model_read(top, 0) || r0 !== 2'b00) begin
            errors++; $display("FAIL wrap_beat1 got %h required %h", d0, model_read(top, 0));
        end
        checks++;
        if (d1 !== model_mem[0] || d1 !== b || r1 !== 2'b00) begin
            errors++; $display("FAIL wrap_beat2 got %h required %h", d1, model_mem[0]);
        end
        checks++;
        if (arr !== 1'b1) begin errors++; $display("FAIL wrap_ar_ready got %b required 1", arr); end
    endtask

    task automatic test_oob();
        logic [63:0] d0, d1; logic [1:0] resp, r0, r1; int lat; bit st, to, to2; logic arr;
        logic [31:0] probe [3];
        logic [31:0] bad   [3];
        probe[0] = BASE + 32'h1000; probe[1] = BASE; probe[2] = BASE + 32'((DEPTH - 1) * 8);
        bad[0] = 32'h00001000; bad[1] = BASE + 32'(DEPTH * 8); bad[2] = BASE - 32'd8;
        for (int i = 0; i < 3; i++) begin
            do_write(probe[i], 0, {$urandom, $urandom}, 64'd0, 8'hFF, 8'h00, resp, to);
            model_write(probe[i], 0, {bus.w_data}, 8'hFF);
        end
        for (int i = 0; i < 3; i++) begin
            do_read(bad[i], 1, 0, d0, d1, r0, r1, lat, st, arr, to2);
            checks++;
            if (to2 || d0 !== 64'd0 || d1 !== 64'd0 || r0 !== 2'b10 || r1 !== 2'b10) begin
                errors++;
                $display("FAIL oob_read addr=%h got %h/%b %h/%b required 0/10 0/10", bad[i], d0, r0, d1, r1);
            end
            do_write(bad[i], 0, 64'hDEADBEEFCAFEF00D, 64'd0, 8'hFF, 8'h00, resp, to);
            checks++;
            if (to || resp !== 2'b10) begin
                errors++; $display("FAIL oob_bresp addr=%h got %b required 10", bad[i], resp);
            end
        end
        for (int i = 0; i < 3; i++) begin
            do_read(probe[i], 0, 0, d0, d1, r0, r1, lat, st, arr, to2);
            checks++;
            if (to2 || d0 !== model_read(probe[i], 0)) begin
                errors++; $display("FAIL oob_unchanged addr=%h got %h required %h", probe[i], d0, model_read(probe[i], 0));
            end
        end
    endtask

    task automatic test_concurrent();
        logic [63:0] oldv, newv, got, d0, d1; logic [1:0] resp, r0, r1, bresp; int lat, n; bit st, to, to2;
        logic arr; logic [31:0] addr;
        addr = BASE + 32'd40;
        oldv = {$urandom, $urandom}; newv = ~oldv;
        do_write(addr, 0, oldv, 64'd0, 8'hFF, 8'h00, resp, to);
        model_write(addr, 0, oldv, 8'hFF);
        bus.aw_addr = addr; bus.aw_len = 0; bus.aw_valid = 1;
        n = 0;
        while (bus.aw_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) to = 1;
        @(negedge clk); bus.aw_valid = 0;
        bus.w_data = newv; bus.w_strb = 8'hFF; bus.w_valid = 1;
        bus.ar_addr = addr; bus.ar_len = 0; bus.ar_valid = 1;
        checks++;
        if (bus.w_ready !== 1'b1 || bus.ar_ready !== 1'b1) begin
            errors++; $display("FAIL coll_ready w_ready=%b ar_ready=%b required 1 1", bus.w_ready, bus.ar_ready);
        end
        @(negedge clk); bus.w_valid = 0; bus.ar_valid = 0;
        bus.r_ready = 1;
        n = 0;
        while (bus.r_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) to = 1;
        got = bus.r_data;
        @(negedge clk); bus.r_ready = 0; bus.b_ready = 1;
        n = 0;
        while (bus.b_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) to = 1;
        bresp = bus.b_resp;
        @(negedge clk); bus.b_ready = 0;
        checks++;
        if (to || got !== model_read(addr, 0) || bresp !== 2'b00) begin
            errors++; $display("FAIL coll_old got %h/%b required %h/00", got, bresp, model_read(addr, 0));
        end
        model_write(addr, 0, newv, 8'hFF);
        do_read(addr, 0, 0, d0, d1, r0, r1, lat, st, arr, to2);
        checks++;
        if (to2 || d0 !== model_read(addr, 0)) begin
            errors++; $display("FAIL coll_new got %h required %h", d0, model_read(addr, 0));
        end
    endtask

    task automatic test_random();
        logic [63:0] d0, d1, g0, g1; logic [7:0] s0, s1; logic [1:0] resp, r0, r1, er;
        int lat, sel; bit st, to; logic arr, len; logic [31:0] addr;
        for (int i = 0; i <= 16; i++) begin
            d0 = {$urandom, $urandom};
            do_write(BASE + 32'(i * 8), 0, d0, 64'd0, 8'hFF, 8'h00, resp, to);
            model_write(BASE + 32'(i * 8), 0, d0, 8'hFF);
        end
        for (int t = 0; t < 80; t++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      addr = 32'($urandom_range(0, 32'h7FFFFFFF));
            else if (sel == 1) addr = BASE + 32'(DEPTH * 8) + 32'($urandom_range(0, 4095));
            else if (sel == 2) addr = BASE + 32'((DEPTH - 1) * 8) + 32'($urandom_range(0, 7));
            else               addr = BASE + 32'($urandom_range(0, 15) * 8) + 32'($urandom_range(0, 7));
            len = 1'($urandom_range(0, 1));
            er  = model_ok(addr) ? 2'b00 : 2'b10;
            if ($urandom_range(0, 1) == 1) begin
                d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
                s0 = 8'($urandom); s1 = 8'($urandom);
                do_write(addr, len, d0, d1, s0, s1, resp, to);
                model_write(addr, 0, d0, s0);
                if (len) model_write(addr, 1, d1, s1);
                checks++;
                if (to || resp !== er) begin
                    errors++; $display("FAIL rand_write t=%0d addr=%h got %b required %b", t, addr, resp, er);
                end
            end else begin
                do_read(addr, len, int'($urandom_range(0, 2)), g0, g1, r0, r1, lat, st, arr, to);
                checks++;
                if (to || !st || g0 !== model_read(addr, 0) || r0 !== er ||
                    (len && (g1 !== model_read(addr, 1) || r1 !== er))) begin
                    errors++;
                    $display("FAIL rand_read t=%0d addr=%h len=%0d got %h/%b %h/%b required %h/%b %h",
                             t, addr, len, g0, r0, g1, r1, model_read(addr, 0), er, model_read(addr, 1));
                end
            end
        end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_basic();
        test_strobe();
        test_wrap();
        test_oob();
        test_concurrent();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
